gj_axis_uart_rx: RTL and testbench

UART receiver that consumes the 16x oversampling strobe from the baud-rate generator and turns the serial `rxd` line into an AXI-Stream byte stream. It samples each bit three times around the bit centre and takes a majority vote. It validates start and stop bits and flags framing errors on `tuser`. It sits between the baud-rate generator and the downstream AXIS consumer (FIFO or register bridge).

---
 rtl/gj_axis_uart_rx.sv | 164 ++++++++++++++++
 tb/tb_gj_axis_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gj_axis_uart_rx.sv
// Purpose: 16x-oversampled UART receiver (8N1, 3-sample majority vote) presenting bytes on AXI-Stream, tuser = framing error.
// Latency: SYNC_STAGES clk + 0..1 strobe detection jitter + 153 strobes + 1 clk from rxd falling edge to tvalid.
// Backpressure: single output register; tready never stalls reception, a byte completing while the register is still full is dropped with an overrun pulse.
module gj_axis_uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_enX16,
    input  logic       rxd,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tuser,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   rxs;

    rxState_t state, stateNext;
    logic [3:0] tick, tickNext;
    logic [2:0] bitCnt, bitCntNext;
    logic       armed, armedNext;
    logic [7:0] shiftReg, shiftNext;
    // Samples from ticks 7 and 8; the tick-9 sample is the live rxs, used in the same strobe as the decision.
    logic [1:0] voteQ, voteNext;
    logic       vote;
    logic       deliver;

    // Metastability synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncQ <= '1;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxs  = syncQ[SYNC_STAGES-1];
    assign vote = (voteQ[0] & voteQ[1]) | (voteQ[0] & rxs) | (voteQ[1] & rxs);
    assign busy = (state != IDLE);

    // Receiver state register plus tick, bit counter, arm flag, shift and vote registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick     <= 4'd0;
            bitCnt   <= 3'd0;
            armed    <= 1'b0;
            shiftReg <= 8'h00;
            voteQ    <= 2'b11;
        end else begin
            state    <= stateNext;
            tick     <= tickNext;
            bitCnt   <= bitCntNext;
            armed    <= armedNext;
            shiftReg <= shiftNext;
            voteQ    <= voteNext;
        end
    end

    // Next-state logic; everything advances only on a 16x strobe and holds otherwise.
    always_comb begin
        stateNext  = state;
        tickNext   = tick;
        bitCntNext = bitCnt;
        armedNext  = armed;
        shiftNext  = shiftReg;
        voteNext   = voteQ;
        deliver    = 1'b0;
        if (clk_enX16) begin
            case (state)
                IDLE: begin
                    tickNext = 4'd0;
                    if (rxs) begin
                        armedNext = 1'b1;
                    end else if (armed) begin
                        // The detection strobe itself is tick 0, so the next strobe is tick 1.
                        stateNext = START;
                        tickNext  = 4'd1;
                        armedNext = 1'b0;
                    end
                end
                START: begin
                    tickNext = tick + 4'd1;
                    if ((tick == 4'd9) && vote) begin
                        stateNext = IDLE;
                        tickNext  = 4'd0;
                    end else if (tick == 4'd15) begin
                        stateNext  = DATA;
                        bitCntNext = 3'd0;
                    end
                end
                DATA: begin
                    tickNext = tick + 4'd1;
                    if (tick == 4'd9) begin
                        shiftNext = {vote, shiftReg[7:1]};
                    end
                    if (tick == 4'd15) begin
                        bitCntNext = bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            stateNext = STOP;
                        end
                    end
                end
                STOP: begin
                    tickNext = tick + 4'd1;
                    // Leave at the stop-bit centre so a back-to-back start bit is caught.
                    if (tick == 4'd9) begin
                        deliver   = 1'b1;
                        stateNext = IDLE;
                        tickNext  = 4'd0;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    tickNext  = 4'd0;
                end
            endcase
            if (state != IDLE) begin
                if (tick == 4'd7) begin
                    voteNext[0] = rxs;
                end
                if (tick == 4'd8) begin
                    voteNext[1] = rxs;
                end
            end
        end
    end

    // AXIS output register: load a finished byte if the slot is free or being drained, else flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tdata  <= 8'h00;
            m_axis_tuser  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (deliver) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tdata  <= shiftReg;
                    m_axis_tuser  <= ~vote;
                    m_axis_tvalid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gj_axis_uart_rx.sv
// Purpose: directed bench for gj_axis_uart_rx with a queue scoreboard and an independent output monitor.
// Latency: strobe every 4 clocks, one bit = 16 strobes; rxd is driven one time unit after a strobe edge.
// Backpressure: tready is held low in the overrun scenario, high elsewhere.
module tb_gj_axis_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_enX16;
    logic       rxd;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tuser;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       overrun;
    logic       busy;

    gj_axis_uart_rx #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_enX16     (clk_enX16),
        .rxd           (rxd),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int beats       = 0;
    int ovCount     = 0;
    int stabErr     = 0;
    int lastRise    = -1;
    int tFall       = 0;
    logic       heldPrev  = 1'b0;
    logic       prevValid = 1'b0;
    logic [8:0] heldDat   = 9'h000;
    logic [8:0] expV;
    logic [8:0] expQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    // One strobe every fourth clock, changed on the falling edge.
    initial begin
        clk_enX16 = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            clk_enX16 = 1'b1;
            @(negedge clk);
            clk_enX16 = 1'b0;
        end
    end

    // Monitor: pop and compare on each accepted beat, count overruns, watch hold stability.
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            vectors++;
            beats++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got user=%0b data=0x%02h, required no beat", m_axis_tuser, m_axis_tdata);
            end else begin
                expV = expQ.pop_front();
                if ({m_axis_tuser, m_axis_tdata} !== expV) begin
                    miscompares++;
                    $display("FAIL beat: got user=%0b data=0x%02h, required user=%0b data=0x%02h",
                             m_axis_tuser, m_axis_tdata, expV[8], expV[7:0]);
                end
            end
        end
        if (overrun === 1'b1) ovCount++;
        if (heldPrev && !(m_axis_tvalid === 1'b1 && {m_axis_tuser, m_axis_tdata} === heldDat)) stabErr++;
        heldPrev = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
        heldDat  = {m_axis_tuser, m_axis_tdata};
        if (m_axis_tvalid === 1'b1 && prevValid === 1'b0) lastRise = cyc;
        prevValid = m_axis_tvalid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic waitStrobes(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (clk_enX16 !== 1'b1);
        end
        #1;
    endtask

    // Drive nSlots strobe slots of a frame; slot s is seen by the DUT as strobe s after start detection.
    task automatic sendSlots(input logic [7:0] d, input logic stopBit, input bit spike, input int nSlots);
        logic b;
        int   bi;
        for (int s = 0; s < nSlots; s++) begin
            bi = s / 16;
            if (bi == 0)      b = 1'b0;
            else if (bi <= 8) b = d[bi-1];
            else              b = stopBit;
            if (spike && (s % 16 == 8) && bi >= 1 && bi <= 8) b = ~b;
            if (s == 0) tFall = cyc;
            rxd = b;
            waitStrobes(1);
        end
    endtask

    int b0, o0;

    initial begin
        rst           = 1'b1;
        rxd           = 1'b1;
        m_axis_tready = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid",  m_axis_tvalid, 0);
        check("rst_tdata",   m_axis_tdata,  8'h00);
        check("rst_tuser",   m_axis_tuser,  0);
        check("rst_overrun", overrun,       0);
        check("rst_busy",    busy,          0);
        waitStrobes(20);

        // 0x55, good stop, tready high: single-cycle tvalid at the specified latency.
        b0 = beats; lastRise = -1;
        expQ.push_back({1'b0, 8'h55});
        sendSlots(8'h55, 1'b1, 0, 160);
        rxd = 1'b1;
        waitStrobes(8);
        vectors++;
        if (lastRise - tFall < 615 || lastRise - tFall > 618) begin
            miscompares++;
            $display("FAIL latency_55: actual %0d cycles required 615..618", lastRise - tFall);
        end
        check("beats_55", beats - b0, 1);
        check("tvalid_after_55", m_axis_tvalid, 0);

        // 0xA3 then 0x0F back-to-back with tready low: A3 held, 0F overruns.
        m_axis_tready = 1'b0;
        b0 = beats; o0 = ovCount;
        expQ.push_back({1'b0, 8'hA3});
        sendSlots(8'hA3, 1'b1, 0, 160);
        sendSlots(8'h0F, 1'b1, 0, 160);
        rxd = 1'b1;
        waitStrobes(16);
        check("overrun_cnt", ovCount - o0, 1);
        check("held_tvalid", m_axis_tvalid, 1);
        check("held_tdata", m_axis_tdata, 8'hA3);
        check("held_tuser", m_axis_tuser, 0);
        m_axis_tready = 1'b1;
        waitStrobes(4);
        check("beats_a3_only", beats - b0, 1);

        // 0x3C with stop low held 2 bit-times, then clean 0x81.
        b0 = beats;
        expQ.push_back({1'b1, 8'h3C});
        sendSlots(8'h3C, 1'b0, 0, 160);
        rxd = 1'b0;
        waitStrobes(16);
        rxd = 1'b1;
        waitStrobes(32);
        expQ.push_back({1'b0, 8'h81});
        sendSlots(8'h81, 1'b1, 0, 160);
        rxd = 1'b1;
        waitStrobes(20);
        check("beats_framing", beats - b0, 2);

        // 5-strobe low glitch: false start, no output.
        b0 = beats; o0 = ovCount;
        rxd = 1'b0;
        waitStrobes(3);
        check("glitch_busy", busy, 1);
        waitStrobes(2);
        rxd = 1'b1;
        waitStrobes(30);
        check("glitch_idle", busy, 0);
        check("glitch_beats", beats - b0, 0);
        check("glitch_overrun", ovCount - o0, 0);

        // 0xC6 with a one-strobe inverted spike at tick 8 of each data bit.
        b0 = beats;
        expQ.push_back({1'b0, 8'hC6});
        sendSlots(8'hC6, 1'b1, 1, 160);
        rxd = 1'b1;
        waitStrobes(20);
        check("beats_spike", beats - b0, 1);

        // Reset during data bit 4, then 0x7E.
        b0 = beats; o0 = ovCount;
        sendSlots(8'h99, 1'b1, 0, 88);
        rst = 1'b1;
        rxd = 1'b1;
        waitStrobes(2);
        rst = 1'b0;
        waitStrobes(40);
        check("abort_busy", busy, 0);
        check("abort_beats", beats - b0, 0);
        check("abort_overrun", ovCount - o0, 0);
        expQ.push_back({1'b0, 8'h7E});
        sendSlots(8'h7E, 1'b1, 0, 160);
        rxd = 1'b1;
        waitStrobes(20);
        check("beats_7e", beats - b0, 1);

        // Break: line low for 3 frames yields exactly one 0x00 with framing error.
        b0 = beats;
        expQ.push_back({1'b1, 8'h00});
        rxd = 1'b0;
        waitStrobes(480);
        rxd = 1'b1;
        waitStrobes(40);
        check("beats_break", beats - b0, 1);

        check("queue_empty", expQ.size(), 0);
        check("hold_stability", stabErr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
